pc_gen: RTL

//  Parametrised program-counter generator for the IF stage. Holds the fetch PC,

---
 rtl/pc_gen_pkg.sv | 21 ++
 rtl/pc_gen_redirect_arb.sv | 49 ++++
 rtl/pc_gen.sv | 118 +++++++++++
 3 files changed

// File: rtl/pc_gen_pkg.sv
// ============================================================================
// pc_gen_pkg : redirect priority codes and PC-generator FSM state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package pc_gen_pkg;

  localparam logic [1:0] PRIO_NONE = 2'd0;
  localparam logic [1:0] PRIO_JMP  = 2'd1;
  localparam logic [1:0] PRIO_BR   = 2'd2;
  localparam logic [1:0] PRIO_EXC  = 2'd3;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } pc_state_t;

endpackage

`default_nettype wire

// File: rtl/pc_gen_redirect_arb.sv
// ============================================================================
// redirect_arb : combinational 3-slot priority select; on equal priority the
//                lower-numbered slot wins. Rev 1.0
// ============================================================================
`default_nettype none

module redirect_arb
  import pc_gen_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              a_valid,
  input  logic [1:0]        a_prio,
  input  logic [ADDR_W-1:0] a_target,
  input  logic              b_valid,
  input  logic [1:0]        b_prio,
  input  logic [ADDR_W-1:0] b_target,
  input  logic              c_valid,
  input  logic [1:0]        c_prio,
  input  logic [ADDR_W-1:0] c_target,
  output logic              sel_valid,
  output logic [1:0]        sel_prio,
  output logic [ADDR_W-1:0] sel_target
);

  always_comb begin
    sel_valid  = 1'b0;
    sel_prio   = PRIO_NONE;
    sel_target = '0;
    if (c_valid) begin
      sel_valid  = 1'b1;
      sel_prio   = c_prio;
      sel_target = c_target;
    end
    if (b_valid && (!sel_valid || (b_prio >= sel_prio))) begin
      sel_valid  = 1'b1;
      sel_prio   = b_prio;
      sel_target = b_target;
    end
    if (a_valid && (!sel_valid || (a_prio >= sel_prio))) begin
      sel_valid  = 1'b1;
      sel_prio   = a_prio;
      sel_target = a_target;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_gen.sv
// ============================================================================
// pc_gen : IF-stage program counter with prioritised redirects and a
//          single-entry pending slot that survives pipeline hold. Rev 1.0
// ============================================================================
`default_nettype none

module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = 32'h00400000,
  parameter logic [ADDR_W-1:0] EXC_VEC   = 32'h80000180,
  parameter int                STEP      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PC_Hold,
  input  logic              exc_valid,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              jmp_valid,
  input  logic [ADDR_W-1:0] jmp_target,
  output logic [ADDR_W-1:0] PC_o,
  output logic [ADDR_W-1:0] PC_plus4_o,
  output logic              pend_o,
  output logic              misalign_o
);

  localparam logic [ADDR_W-1:0] c_step = ADDR_W'(STEP);

  pc_state_t         r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [1:0]        r_pend_prio, w_pend_prio_nxt;
  logic [ADDR_W-1:0] r_pend_tgt, w_pend_tgt_nxt;
  logic              r_mis, w_mis_nxt;

  logic              w_in_valid, w_sel_valid;
  logic [1:0]        w_in_prio, w_sel_prio;
  logic [ADDR_W-1:0] w_in_tgt, w_sel_tgt;

  redirect_arb #(.ADDR_W(ADDR_W)) u_arb_in (
    .a_valid   (exc_valid),
    .a_prio    (PRIO_EXC),
    .a_target  (EXC_VEC),
    .b_valid   (br_valid),
    .b_prio    (PRIO_BR),
    .b_target  (br_target),
    .c_valid   (jmp_valid),
    .c_prio    (PRIO_JMP),
    .c_target  (jmp_target),
    .sel_valid (w_in_valid),
    .sel_prio  (w_in_prio),
    .sel_target(w_in_tgt)
  );

  // New request sits in slot a so that an equal priority replaces the stored one.
  redirect_arb #(.ADDR_W(ADDR_W)) u_arb_pend (
    .a_valid   (w_in_valid),
    .a_prio    (w_in_prio),
    .a_target  (w_in_tgt),
    .b_valid   (r_state == ST_PEND),
    .b_prio    (r_pend_prio),
    .b_target  (r_pend_tgt),
    .c_valid   (1'b0),
    .c_prio    (PRIO_NONE),
    .c_target  ({ADDR_W{1'b0}}),
    .sel_valid (w_sel_valid),
    .sel_prio  (w_sel_prio),
    .sel_target(w_sel_tgt)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_pend_prio_nxt = r_pend_prio;
    w_pend_tgt_nxt  = r_pend_tgt;
    w_mis_nxt       = 1'b0;
    if (PC_Hold) begin
      if (w_sel_valid) begin
        w_state_nxt     = ST_PEND;
        w_pend_prio_nxt = w_sel_prio;
        w_pend_tgt_nxt  = w_sel_tgt;
      end
    end else begin
      w_state_nxt = ST_RUN;
      if (w_sel_valid) begin
        w_pc_nxt  = {w_sel_tgt[ADDR_W-1:2], 2'b00};
        w_mis_nxt = (w_sel_prio != PRIO_EXC) && (w_sel_tgt[1:0] != 2'b00);
      end else begin
        w_pc_nxt = r_pc + c_step;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_pc        <= RESET_VEC;
      r_pend_prio <= PRIO_NONE;
      r_pend_tgt  <= '0;
      r_mis       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_pend_prio <= w_pend_prio_nxt;
      r_pend_tgt  <= w_pend_tgt_nxt;
      r_mis       <= w_mis_nxt;
    end
  end

  assign PC_o       = r_pc;
  assign PC_plus4_o = r_pc + c_step;
  assign pend_o     = (r_state == ST_PEND);
  assign misalign_o = r_mis;

endmodule

`default_nettype wire
